nonrestoring_divider_module: RTL and testbench

Iterative unsigned non-restoring divider: the inverse arithmetic companion of the pipelined Booth multiplier. It accepts a dividend/divisor pair on a start strobe and computes one quotient bit per clock. It returns quotient and remainder with a one-cycle done pulse. It sits beside the multiplier in the arithmetic experiments and lets multiply-then-divide round trips be checked on hardware.

---
 rtl/nonrestoring_divider_module.sv | 122 ++++++++++++
 tb/tb_nonrestoring_divider_module.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/nonrestoring_divider_module.sv
// Iterative unsigned non-restoring divider: one quotient bit per clock,
// registered quotient/remainder with a one-cycle done pulse.
module nonrestoring_divider_module #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_sig,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero,
    output logic             busy,
    output logic             done_sig
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t           state_reg, state_next;
    logic [WIDTH:0]   r_reg, r_next;
    logic [WIDTH-1:0] q_reg, q_next;
    logic [WIDTH-1:0] d_reg, d_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic [WIDTH-1:0] quot_reg, quot_next;
    logic [WIDTH-1:0] rem_reg, rem_next;
    logic             dz_reg, dz_next;
    logic             done_reg, done_next;

    logic [WIDTH:0]   d_ext, r_shift, r_iter, r_fix;

    // Add or subtract the divisor depending on the sign of the pre-shift remainder.
    assign d_ext   = {1'b0, d_reg};
    assign r_shift = {r_reg[WIDTH-1:0], q_reg[WIDTH-1]};
    assign r_iter  = r_reg[WIDTH] ? (r_shift + d_ext) : (r_shift - d_ext);
    assign r_fix   = r_reg[WIDTH] ? (r_reg + d_ext) : r_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            r_reg     <= '0;
            q_reg     <= '0;
            d_reg     <= '0;
            cnt_reg   <= '0;
            quot_reg  <= '0;
            rem_reg   <= '0;
            dz_reg    <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            r_reg     <= r_next;
            q_reg     <= q_next;
            d_reg     <= d_next;
            cnt_reg   <= cnt_next;
            quot_reg  <= quot_next;
            rem_reg   <= rem_next;
            dz_reg    <= dz_next;
            done_reg  <= done_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        r_next     = r_reg;
        q_next     = q_reg;
        d_next     = d_reg;
        cnt_next   = cnt_reg;
        quot_next  = quot_reg;
        rem_next   = rem_reg;
        dz_next    = dz_reg;
        done_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start_sig) begin
                    if (divisor == '0) begin
                        // Divide by zero short-circuits straight to a result.
                        quot_next  = '1;
                        rem_next   = dividend;
                        dz_next    = 1'b1;
                        done_next  = 1'b1;
                        state_next = DONE;
                    end else begin
                        r_next     = '0;
                        q_next     = dividend;
                        d_next     = divisor;
                        cnt_next   = '0;
                        state_next = CALC;
                    end
                end
            end
            CALC: begin
                r_next   = r_iter;
                q_next   = {q_reg[WIDTH-2:0], ~r_iter[WIDTH]};
                cnt_next = cnt_reg + 1'b1;
                if (cnt_reg == CW'(WIDTH - 1)) begin
                    state_next = FIX;
                end
            end
            FIX: begin
                rem_next   = r_fix[WIDTH-1:0];
                quot_next  = q_reg;
                dz_next    = 1'b0;
                done_next  = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign quotient  = quot_reg;
    assign remainder = rem_reg;
    assign div_zero  = dz_reg;
    assign done_sig  = done_reg;
    assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_nonrestoring_divider_module.sv
// Directed bench for nonrestoring_divider_module (WIDTH=8): checks results,
// latency, busy length, ignored starts, mid-operation reset and back-to-back spacing.
module tb_nonrestoring_divider_module;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start_sig = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_zero;
    logic         busy;
    logic         done_sig;

    int checks = 0;
    int errors = 0;

    nonrestoring_divider_module #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start_sig (start_sig),
        .dividend  (dividend),
        .divisor   (divisor),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero),
        .busy      (busy),
        .done_sig  (done_sig)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Issue one operation, measure edges from the start edge to done_sig and
    // busy cycles, then check the result and the return to idle.
    task automatic run_op(input string tag, input int a, input int b,
                          input int exp_q, input int exp_r, input int exp_dz,
                          input int exp_lat, input int exp_busy);
        int lat;
        int bcnt;
        @(negedge clk);
        dividend  = W'(a);
        divisor   = W'(b);
        start_sig = 1'b1;
        @(posedge clk);
        #1;
        start_sig = 1'b0;
        lat  = 0;
        bcnt = 0;
        while (!done_sig && lat < 40) begin
            bcnt += int'(busy);
            @(posedge clk);
            #1;
            lat++;
        end
        bcnt += int'(busy);
        chk({tag, " latency"}, lat, exp_lat);
        chk({tag, " quotient"}, quotient, exp_q);
        chk({tag, " remainder"}, remainder, exp_r);
        chk({tag, " div_zero"}, div_zero, exp_dz);
        if (exp_busy >= 0) chk({tag, " busy_cycles"}, bcnt, exp_busy);
        @(posedge clk);
        #1;
        chk({tag, " done_low"}, done_sig, 0);
        chk({tag, " busy_low"}, busy, 0);
        chk({tag, " quotient_held"}, quotient, exp_q);
    endtask

    initial begin
        int npulse;
        int pulse_edge;
        int pulse_q;
        int pulse_r;
        int edge_n;
        int last_done;
        int ops;
        int cur_a;
        int cur_b;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst quotient", quotient, 0);
        chk("rst remainder", remainder, 0);
        chk("rst div_zero", div_zero, 0);
        chk("rst busy", busy, 0);
        chk("rst done", done_sig, 0);
        @(negedge clk);
        rst = 1'b0;

        // Main cases and boundaries: done 9 edges after start, busy 10 cycles
        run_op("100/7", 100, 7, 14, 2, 0, 9, 10);
        run_op("255/1", 255, 1, 255, 0, 0, 9, 10);
        run_op("5/9", 5, 9, 0, 5, 0, 9, 10);
        run_op("255/255", 255, 255, 1, 0, 0, 9, 10);
        run_op("0/3", 0, 3, 0, 0, 0, 9, 10);
        run_op("201/16", 201, 16, 12, 9, 0, 9, 10);

        // Divide by zero: result registered on the start edge itself
        run_op("200/0", 200, 0, 255, 200, 1, 0, -1);
        run_op("50/7", 50, 7, 7, 1, 0, 9, 10);

        // Starts during CALC and FIX must be ignored
        @(negedge clk);
        dividend  = 8'd100;
        divisor   = 8'd7;
        start_sig = 1'b1;
        @(posedge clk);
        #1;
        start_sig  = 1'b0;
        npulse     = 0;
        pulse_edge = 0;
        pulse_q    = 0;
        pulse_r    = 0;
        for (int e = 1; e <= 10; e++) begin
            @(negedge clk);
            if (e == 3 || e == 9) begin
                start_sig = 1'b1;
                dividend  = 8'd9;
                divisor   = 8'd3;
            end else begin
                start_sig = 1'b0;
            end
            @(posedge clk);
            #1;
            if (done_sig) begin
                npulse++;
                pulse_edge = e;
                pulse_q    = int'(quotient);
                pulse_r    = int'(remainder);
            end
        end
        start_sig = 1'b0;
        chk("ignore pulses", npulse, 1);
        chk("ignore edge", pulse_edge, 9);
        chk("ignore quotient", pulse_q, 14);
        chk("ignore remainder", pulse_r, 2);
        chk("ignore busy_low", busy, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("ignore held_q", quotient, 14);
        chk("ignore held_r", remainder, 2);

        // Reset at iteration 4 abandons the operation
        @(negedge clk);
        dividend  = 8'd100;
        divisor   = 8'd7;
        start_sig = 1'b1;
        @(posedge clk);
        #1;
        start_sig = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst quotient", quotient, 0);
        chk("midrst remainder", remainder, 0);
        chk("midrst div_zero", div_zero, 0);
        chk("midrst busy", busy, 0);
        chk("midrst done", done_sig, 0);
        @(negedge clk);
        rst = 1'b0;
        npulse = 0;
        repeat (15) begin
            @(posedge clk);
            #1;
            if (done_sig) npulse++;
        end
        chk("midrst no_done", npulse, 0);
        run_op("after_rst 100/7", 100, 7, 14, 2, 0, 9, 10);

        // Back-to-back operations under continuous start_sig
        @(negedge clk);
        cur_a     = int'($urandom_range(0, 255));
        cur_b     = int'($urandom_range(1, 255));
        dividend  = W'(cur_a);
        divisor   = W'(cur_b);
        start_sig = 1'b1;
        edge_n    = 0;
        last_done = -1;
        ops       = 0;
        while (ops < 200 && edge_n < 5000) begin
            @(posedge clk);
            #1;
            edge_n++;
            if (done_sig) begin
                chk("sweep quotient", quotient, cur_a / cur_b);
                chk("sweep remainder", remainder, cur_a % cur_b);
                if (last_done >= 0) chk("sweep spacing", edge_n - last_done, W + 3);
                last_done = edge_n;
                ops++;
                cur_a    = int'($urandom_range(0, 255));
                cur_b    = int'($urandom_range(1, 255));
                dividend = W'(cur_a);
                divisor  = W'(cur_b);
            end
        end
        start_sig = 1'b0;
        chk("sweep completed", ops, 200);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
